// File: rtl/boot_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package boot_pkg;

  // Loader sequencing: length header, payload words, checksum, reset hold, run or fail.
  typedef enum logic [2:0] {
    LEN_HI = 3'd0,
    LEN_LO = 3'd1,
    DATA   = 3'd2,
    CHK    = 3'd3,
    HOLD   = 3'd4,
    RUN    = 3'd5,
    ERR    = 3'd6
  } boot_state_t;

  localparam int BYTES_PER_WORD = 4;
  localparam int LEN_BYTES      = 2;

endpackage

// File: rtl/byte_word_assembler.sv
// Collects four stream bytes, MSB first, into a 32-bit word and flags each
// completed word with a one-cycle word_valid. The word register holds its
// value between completions so it can drive the memory data bus directly.
module byte_word_assembler
  import boot_pkg::*;
(
  input  logic        clk,
  input  logic        srst,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        word_last,
  output logic        word_valid,
  output logic [31:0] word_data
);

  logic [1:0]  cnt_reg;
  logic [23:0] shift_reg;
  logic        word_valid_reg;
  logic [31:0] word_reg;

  // The next accepted byte completes the current word.
  assign word_last  = (cnt_reg == 2'(BYTES_PER_WORD - 1));
  assign word_valid = word_valid_reg;
  assign word_data  = word_reg;

  // Shift bytes in, count them, and publish the word on the fourth byte.
  always_ff @(posedge clk) begin
    if (srst) begin
      cnt_reg        <= '0;
      shift_reg      <= '0;
      word_valid_reg <= 1'b0;
      word_reg       <= '0;
    end else begin
      word_valid_reg <= 1'b0;
      if (byte_valid) begin
        cnt_reg   <= cnt_reg + 2'd1;
        shift_reg <= {shift_reg[15:0], byte_data};
        if (word_last) begin
          word_valid_reg <= 1'b1;
          word_reg       <= {shift_reg, byte_data};
        end
      end
    end
  end

endmodule

// File: rtl/imem_boot_loader.sv
// Boot loader: parses a length-prefixed byte image, writes it to instruction
// memory from word 0, verifies an XOR checksum and then releases the CPU reset
// after a short hold. Any framing or checksum problem parks it in ERR with the
// CPU held in reset.
module imem_boot_loader
  import boot_pkg::*;
#(
  parameter int ADDR_W   = 10,
  parameter int RST_HOLD = 4
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_rst,
  output logic              done,
  output logic              error
);

  // Word counter is one bit wider than the address so a full-memory image
  // (N == 2^ADDR_W) reaches its final count without wrapping.
  localparam int          CNT_W    = ADDR_W + 1;
  localparam logic [31:0] CAPACITY = 32'd1 << ADDR_W;

  boot_state_t       state_reg, state_next;
  logic              rx_ready_reg, rx_ready_next;
  logic [ADDR_W-1:0] imem_addr_reg, imem_addr_next;
  logic              cpu_rst_reg, cpu_rst_next;
  logic              done_reg, done_next;
  logic              error_reg, error_next;
  logic [15:0]       len_reg, len_next;
  logic [CNT_W-1:0]  word_cnt_reg, word_cnt_next;
  logic [7:0]        acc_reg, acc_next;
  logic [7:0]        hold_cnt_reg, hold_cnt_next;

  logic              xfer;
  logic              data_byte;
  logic              word_last;
  logic              word_valid;
  logic [31:0]       word_data;
  logic [15:0]       len_in;
  logic [CNT_W-1:0]  word_cnt_inc;
  logic              last_word;

  assign xfer         = rx_valid && rx_ready_reg;
  assign data_byte    = xfer && (state_reg == DATA);
  assign len_in       = {len_reg[15:8], rx_data};
  assign word_cnt_inc = word_cnt_reg + CNT_W'(1);
  assign last_word    = ({{(32 - CNT_W){1'b0}}, word_cnt_inc} == {16'h0000, len_reg});

  byte_word_assembler u_assembler (
    .clk        (Clk),
    .srst       (Rst),
    .byte_valid (data_byte),
    .byte_data  (rx_data),
    .word_last  (word_last),
    .word_valid (word_valid),
    .word_data  (word_data)
  );

  // A word completing in the same cycle Rst is asserted must not reach memory.
  assign imem_we    = word_valid && !Rst;
  assign imem_addr  = imem_addr_reg;
  assign imem_wdata = word_data;
  assign rx_ready   = rx_ready_reg;
  assign cpu_rst    = cpu_rst_reg;
  assign done       = done_reg;
  assign error      = error_reg;

  // State and datapath registers.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_reg     <= LEN_HI;
      rx_ready_reg  <= 1'b1;
      imem_addr_reg <= '0;
      cpu_rst_reg   <= 1'b1;
      done_reg      <= 1'b0;
      error_reg     <= 1'b0;
      len_reg       <= '0;
      word_cnt_reg  <= '0;
      acc_reg       <= '0;
      hold_cnt_reg  <= '0;
    end else begin
      state_reg     <= state_next;
      rx_ready_reg  <= rx_ready_next;
      imem_addr_reg <= imem_addr_next;
      cpu_rst_reg   <= cpu_rst_next;
      done_reg      <= done_next;
      error_reg     <= error_next;
      len_reg       <= len_next;
      word_cnt_reg  <= word_cnt_next;
      acc_reg       <= acc_next;
      hold_cnt_reg  <= hold_cnt_next;
    end
  end

  // Next-state decision.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      LEN_HI: if (xfer) state_next = LEN_LO;
      LEN_LO: begin
        if (xfer) begin
          if ({16'h0000, len_in} > CAPACITY) state_next = ERR;
          else if (len_in == 16'h0000)      state_next = CHK;
          else                              state_next = DATA;
        end
      end
      DATA:   if (word_valid && last_word) state_next = CHK;
      CHK:    if (xfer) state_next = (rx_data == acc_reg) ? HOLD : ERR;
      HOLD:   if (hold_cnt_reg == 8'(RST_HOLD - 1)) state_next = RUN;
      RUN:    state_next = RUN;
      ERR:    state_next = ERR;
      default: state_next = LEN_HI;
    endcase
  end

  // Registered outputs and datapath updates derived from state and next state.
  always_comb begin
    len_next       = len_reg;
    acc_next       = acc_reg;
    word_cnt_next  = word_cnt_reg;
    imem_addr_next = imem_addr_reg;
    hold_cnt_next  = '0;

    if (xfer && (state_reg == LEN_HI)) len_next[15:8] = rx_data;
    if (xfer && (state_reg == LEN_LO)) len_next[7:0]  = rx_data;
    if (data_byte) acc_next = acc_reg ^ rx_data;
    // Capture the address as the last byte lands so it lines up with the write.
    if (data_byte && word_last) imem_addr_next = word_cnt_reg[ADDR_W-1:0];
    if (word_valid) word_cnt_next = word_cnt_inc;
    if (state_reg == HOLD) hold_cnt_next = hold_cnt_reg + 8'd1;

    // Accept bytes only in stream states, and pause for the write cycle.
    rx_ready_next = ((state_next == LEN_HI) || (state_next == LEN_LO) ||
                     (state_next == DATA)   || (state_next == CHK)) &&
                    !(data_byte && word_last);
    cpu_rst_next  = (state_next != RUN);
    done_next     = (state_next == RUN);
    error_next    = (state_next == ERR);
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Self-checking bench for imem_boot_loader: expected memory writes are queued
// as each word is driven and popped by a monitor as writes appear.
module tb_imem_boot_loader;

  localparam int ADDR_W   = 10;
  localparam int RST_HOLD = 4;

  logic              Clk = 1'b0;
  logic              Rst;
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              rx_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              cpu_rst;
  logic              done;
  logic              error;

  imem_boot_loader #(.ADDR_W(ADDR_W), .RST_HOLD(RST_HOLD)) dut (
    .Clk        (Clk),
    .Rst        (Rst),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .rx_ready   (rx_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_rst    (cpu_rst),
    .done       (done),
    .error      (error)
  );

  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  wr_t         exp_q[$];
  logic [31:0] img[$];
  int checks    = 0;
  int errors    = 0;
  int wr_cnt    = 0;
  int last_xcyc = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Write monitor: every write must match the oldest queued expectation.
  always @(negedge Clk) begin
    if (imem_we) begin
      wr_t w;
      wr_cnt++;
      $display("write addr=%0d data=%08h", imem_addr, imem_wdata);
      if (exp_q.size() == 0) begin
        check("unexpected_we", 32'd1, 32'd0);
      end else begin
        w = exp_q.pop_front();
        check("wr_addr", 32'(imem_addr), 32'(w.addr));
        check("wr_data", imem_wdata, w.data);
      end
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  function automatic int rgap(input int maxgap);
    return (maxgap == 0) ? 0 : int'($urandom_range(maxgap, 0));
  endfunction

  function automatic logic [7:0] img_xor();
    logic [7:0] x = 8'h00;
    foreach (img[i]) x = x ^ img[i][31:24] ^ img[i][23:16] ^ img[i][15:8] ^ img[i][7:0];
    return x;
  endfunction

  // Offer one byte after an idle gap; acked reports whether it transferred.
  task automatic send_byte(input logic [7:0] b, input int gap, input int budget,
                           output bit acked);
    acked = 1'b0;
    repeat (gap) begin
      rx_valid = 1'b0;
      tick();
    end
    rx_valid = 1'b1;
    rx_data  = b;
    for (int i = 0; i < budget; i++) begin
      if (rx_ready) begin
        tick();
        acked     = 1'b1;
        last_xcyc = cyc;
        break;
      end
      tick();
    end
  endtask

  task automatic send_ok(input logic [7:0] b, input int gap);
    bit acked;
    send_byte(b, gap, 40, acked);
    if (!acked) check("ack_timeout", 32'd0, 32'd1);
  endtask

  task automatic send_image(input logic [15:0] n, input logic [7:0] chk,
                            input int maxgap, input bit push);
    logic [31:0] w;
    wr_t e;
    send_ok(n[15:8], rgap(maxgap));
    send_ok(n[7:0], rgap(maxgap));
    for (int i = 0; i < img.size(); i++) begin
      w = img[i];
      if (push) begin
        e.addr = ADDR_W'(i);
        e.data = w;
        exp_q.push_back(e);
      end
      for (int b = 3; b >= 0; b--) send_ok(w[8*b +: 8], rgap(maxgap));
    end
    send_ok(chk, rgap(maxgap));
    rx_valid = 1'b0;
  endtask

  task automatic wait_fall(input string tag, input int budget, output int fall);
    bit seen = 1'b0;
    fall = -1;
    for (int i = 0; i < budget; i++) begin
      if (!cpu_rst) begin
        fall = cyc;
        seen = 1'b1;
        break;
      end
      tick();
    end
    if (!seen) check(tag, 32'd0, 32'd1);
  endtask

  task automatic do_reset();
    rx_valid = 1'b0;
    Rst = 1'b1;
    tick();
    Rst = 1'b0;
    exp_q.delete();
    wr_cnt = 0;
  endtask

  initial begin
    int fall;
    bit acked;

    Rst      = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (3) tick();
    check("rst_rx_ready", 32'(rx_ready), 32'd1);
    check("rst_imem_we", 32'(imem_we), 32'd0);
    check("rst_imem_addr", 32'(imem_addr), 32'd0);
    check("rst_imem_wdata", imem_wdata, 32'd0);
    check("rst_cpu_rst", 32'(cpu_rst), 32'd1);
    check("rst_done", 32'(done), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    Rst = 1'b0;

    // Two-word image, valid held high, good checksum.
    img = '{32'h20010005, 32'h00000000};
    send_image(16'd2, 8'h24, 0, 1'b1);
    check("t1_cpu_rst_hold", 32'(cpu_rst), 32'd1);
    wait_fall("t1_fall_timeout", 50, fall);
    check("t1_hold_cycles", 32'(fall - last_xcyc), 32'(RST_HOLD));
    check("t1_done", 32'(done), 32'd1);
    check("t1_rx_ready", 32'(rx_ready), 32'd0);
    check("t1_wr_cnt", 32'(wr_cnt), 32'd2);
    $display("load n=2 good checksum: writes=%0d done=%0b", wr_cnt, done);

    // Same image with a bad checksum.
    do_reset();
    send_image(16'd2, 8'h25, 0, 1'b1);
    tick();
    check("t2_error", 32'(error), 32'd1);
    check("t2_cpu_rst", 32'(cpu_rst), 32'd1);
    check("t2_rx_ready", 32'(rx_ready), 32'd0);
    check("t2_done", 32'(done), 32'd0);
    send_byte(8'hAA, 0, 10, acked);
    rx_valid = 1'b0;
    check("t2_late_ack", 32'(acked), 32'd0);
    check("t2_wr_cnt", 32'(wr_cnt), 32'd2);
    $display("load n=2 bad checksum: error=%0b cpu_rst=%0b", error, cpu_rst);

    // Empty image.
    do_reset();
    img.delete();
    send_image(16'd0, 8'h00, 0, 1'b1);
    wait_fall("t3_fall_timeout", 50, fall);
    check("t3_hold_cycles", 32'(fall - last_xcyc), 32'(RST_HOLD));
    check("t3_done", 32'(done), 32'd1);
    check("t3_wr_cnt", 32'(wr_cnt), 32'd0);
    $display("load n=0: done=%0b writes=%0d", done, wr_cnt);

    // Oversized length: one word beyond capacity.
    do_reset();
    send_ok(8'h04, 0);
    send_ok(8'h01, 0);
    rx_valid = 1'b0;
    check("t4_error", 32'(error), 32'd1);
    check("t4_rx_ready", 32'(rx_ready), 32'd0);
    repeat (5) tick();
    check("t4_wr_cnt", 32'(wr_cnt), 32'd0);
    check("t4_cpu_rst", 32'(cpu_rst), 32'd1);
    $display("load n=0x0401: error=%0b", error);

    // Gapped stream aborted by Rst right after the sixth stream byte, then reload.
    do_reset();
    img = '{$urandom(), $urandom(), $urandom()};
    send_ok(8'h00, rgap(5));
    send_ok(8'h03, rgap(5));
    for (int b = 3; b >= 0; b--) send_ok(img[0][8*b +: 8], rgap(5));
    rx_valid = 1'b0;
    Rst = 1'b1;
    tick();
    Rst = 1'b0;
    tick();
    check("t5_abort_wr_cnt", 32'(wr_cnt), 32'd0);
    check("t5_abort_rx_ready", 32'(rx_ready), 32'd1);
    send_image(16'd3, img_xor(), 5, 1'b1);
    wait_fall("t5_fall_timeout", 50, fall);
    check("t5_hold_cycles", 32'(fall - last_xcyc), 32'(RST_HOLD));
    check("t5_done", 32'(done), 32'd1);
    check("t5_wr_cnt", 32'(wr_cnt), 32'd3);
    $display("aborted then reloaded n=3 with gaps: writes=%0d done=%0b", wr_cnt, done);

    // Full-capacity image: last address is 2^ADDR_W-1 and no counter wrap.
    do_reset();
    img.delete();
    for (int i = 0; i < (1 << ADDR_W); i++) img.push_back($urandom());
    send_image(16'(1 << ADDR_W), img_xor(), 0, 1'b1);
    wait_fall("t6_fall_timeout", 50, fall);
    check("t6_done", 32'(done), 32'd1);
    check("t6_error", 32'(error), 32'd0);
    check("t6_wr_cnt", 32'(wr_cnt), 32'(1 << ADDR_W));
    check("t6_queue_left", 32'(exp_q.size()), 32'd0);
    $display("load n=%0d full memory: writes=%0d done=%0b", 1 << ADDR_W, wr_cnt, done);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/imem_boot_loader.md
Name: imem_boot_loader

Overview:
- Boot-time loader that owns the processor's reset and instruction memory write port.
- Receives a byte stream over a valid/ready handshake, assembles 32-bit big-endian words, and writes them to instruction memory from address 0.
- Checks an XOR checksum, then releases `cpu_rst` so the processor starts fetching at 0.
- Sits between the board/bench byte source and `processor`.
- Replaces the bench-driven reset with a loader-generated one.

Parameters:
- ADDR_W, 10, instruction memory word-address width; capacity is 2^ADDR_W words.
- RST_HOLD, 4, cycles `cpu_rst` stays high after a good checksum before release; legal range 1..255.

Ports:
- Clk  in  1  system clock; all logic on the rising edge.
- Rst  in  1  synchronous, active-high reset.
- rx_valid  in  1  source has a byte on `rx_data`.
- rx_data  in  8  stream byte.
- rx_ready  out  1  loader accepts a byte this cycle.
- imem_we  out  1  instruction memory write strobe, one cycle per word.
- imem_addr  out  ADDR_W  word address for the write.
- imem_wdata  out  32  word to write.
- cpu_rst  out  1  processor reset, active-high.
- done  out  1  image loaded and processor released.
- error  out  1  load failed; processor is held in reset.

Behaviour:
- Handshake:
  - A byte transfers on a rising edge where `rx_valid && rx_ready`.
  - The source holds `rx_data` stable while `rx_valid && !rx_ready`.
  - `rx_ready` is registered. It is 1 only in LEN_HI, LEN_LO, DATA and CHK, and 0 in the cycle of a word write.
- Stream format:
  - LEN_HI, LEN_LO: 16-bit word count N, big-endian.
  - Then N words of 4 bytes each, MSB first.
  - Then 1 checksum byte equal to the XOR of all 4N data bytes; the length bytes are excluded.
- Reset values:
  - state=LEN_HI, rx_ready=1, imem_we=0, imem_addr=0, imem_wdata=0.
  - cpu_rst=1, done=0, error=0.
  - Internal byte counter, word counter, length register and checksum accumulator are all 0.
- State machine:
  - LEN_HI: on transfer, latch the high byte; go to LEN_LO.
  - LEN_LO: on transfer, latch the low byte.
    - N > 2^ADDR_W: go to ERR.
    - N == 0: go to CHK.
    - Otherwise: go to DATA.
  - DATA: shift each byte into the word register and XOR it into the accumulator.
    - On the 4th byte of a word, the next cycle asserts `imem_we` for exactly 1 cycle with `imem_addr` = word index and `imem_wdata` = the assembled word. `rx_ready` is 0 during that cycle.
    - Latency from the 4th byte transfer to `imem_we` is 1 cycle.
    - After the write of word N-1, go to CHK.
  - CHK: on transfer, compare the byte to the accumulator.
    - Equal: go to HOLD.
    - Different: go to ERR.
  - HOLD: `rx_ready`=0 and `cpu_rst`=1. Count RST_HOLD cycles, then go to RUN.
  - RUN: `cpu_rst`=0, `done`=1, `rx_ready`=0. Terminal until Rst; later bytes are ignored and never acknowledged.
  - ERR: `error`=1, `cpu_rst`=1, `rx_ready`=0. Terminal until Rst.
- Boundaries:
  - N == 2^ADDR_W is legal. The last address is 2^ADDR_W-1 and the word counter must not wrap before CHK.
  - `rx_valid` gaps of any length mid-word are tolerated; partial words are preserved.
  - Rst mid-stream discards the partial word and accumulator. No write occurs in the cycle Rst is high, and the loader restarts at LEN_HI.
  - Rst during RUN re-asserts `cpu_rst` on the next edge.
- `imem_addr` and `imem_wdata` hold their last values when `imem_we`=0.

Decomposition:
- Shared package `boot_pkg`:
  - State enum: LEN_HI, LEN_LO, DATA, CHK, HOLD, RUN, ERR.
  - Constants BYTES_PER_WORD=4 and LEN_BYTES=2.
- One natural sub-module, `byte_word_assembler`:
  - Byte shift register plus 2-bit byte counter.
  - Emits a one-cycle `word_valid` with the 32-bit word.
- The FSM, counters, checksum and reset-hold logic stay in `imem_boot_loader`.

Test Plan:
- N=2, words 0x20010005 and 0x00000000, checksum 0x24, `rx_valid` held high:
  - Expect exactly 2 `imem_we` pulses at addr 0 and 1 with those data values.
  - Expect `cpu_rst` falling exactly RST_HOLD=4 cycles after the checksum transfer, and `done`=1.
- Same image with a wrong checksum 0x25:
  - Expect `error`=1, `cpu_rst` stays 1, `rx_ready`=0.
  - Later bytes are not acknowledged.
- N=0 then checksum 0x00:
  - Expect no `imem_we`; HOLD then RUN.
- N=0x0401 with ADDR_W=10:
  - Expect ERR right after LEN_LO and no writes.
- Random 0–5 cycle `rx_valid` gaps inside words plus a Rst pulse after byte 6 of the first load:
  - Expect no write from the aborted load.
  - A full reload then writes correct words from addr 0.
